// File: rtl/bellek_islem_birimi_p.sv
// bellek_islem_birimi_p: load/store unit between the execute stage and the
// data bus. Handles B/H/W(/D) accesses on a word-granular bus with lane
// steering, sign/zero extension and bus/pipeline stall handshakes.
// Optional macro BIB_HIZASIZ_EN: when defined, misaligned accesses are split
// into two bus beats; when undefined they complete at once with a fault.
module bellek_islem_birimi_p #(
  parameter int VERI_BIT = 32,
  parameter int ADR_BIT  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  basla_i,
  output logic                  bitti_o,
  input  logic                  ddb_durdur_i,
  input  logic [3:0]            kontrol_i,
  input  logic [ADR_BIT-1:0]    adr_i,
  input  logic [VERI_BIT-1:0]   deger_i,
  output logic [VERI_BIT-1:0]   sonuc_o,
  output logic                  hata_o,
  input  logic [VERI_BIT-1:0]   bib_veri_i,
  input  logic                  bib_durdur_i,
  output logic [VERI_BIT-1:0]   bib_veri_o,
  output logic [ADR_BIT-1:0]    bib_adr_o,
  output logic [VERI_BIT/8-1:0] bib_veri_maske_o,
  output logic                  bib_yaz_gecerli_o,
  output logic                  bib_sec_o
);

  localparam int BAYT = VERI_BIT / 8;
  localparam int OFS  = $clog2(BAYT);

`ifdef BIB_HIZASIZ_EN
  localparam bit HIZASIZ = 1'b1;
`else
  localparam bit HIZASIZ = 1'b0;
`endif

  typedef enum logic [1:0] {BOSTA, ISTEK1, ISTEK2, SONUC} durum_t;

  durum_t durum_reg, durum_next;

  // Captured operation
  logic                yaz_reg;
  logic                isaretsiz_reg;
  logic [1:0]          boyut_reg;
  logic [ADR_BIT-1:0]  adr_reg;
  logic [VERI_BIT-1:0] deger_reg;
  logic                hizasiz_reg;
  logic [VERI_BIT-1:0] veri1_reg;
  logic [VERI_BIT-1:0] sonuc_reg;
  logic                hata_reg;

  // FSM control strobes
  logic yakala;
  logic hata_next;
  logic veri1_al;
  logic sonuc_al;

  // True when the access crosses a bus-word boundary.
  function automatic logic hizasiz_f(input logic [OFS-1:0] ofs, input logic [1:0] boyut);
    logic [4:0] toplam;
    toplam = 5'(ofs) + (5'd1 << boyut);
    return toplam > 5'(BAYT);
  endfunction

  // Double access on a 32-bit bus, or an "unsigned" store, is illegal.
  function automatic logic yasak_f(input logic [1:0] boyut, input logic isaretsiz, input logic yaz);
    return ((boyut == 2'd3) && (VERI_BIT == 32)) || (isaretsiz && yaz);
  endfunction

  // Lane masks: boy_maske marks the low n bytes, bayt_maske the same per bit.
  logic [BAYT-1:0]     boy_maske;
  logic [VERI_BIT-1:0] bayt_maske;

  generate
    for (genvar gi = 0; gi < BAYT; gi++) begin : g_serit
      assign boy_maske[gi]          = (4'(gi) < (4'd1 << boyut_reg));
      assign bayt_maske[gi*8 +: 8]  = {8{boy_maske[gi]}};
    end
  endgenerate

  logic [OFS+2:0]        kaydirma;
  logic [2*BAYT-1:0]     maske_genis;
  logic [2*VERI_BIT-1:0] veri_genis;
  logic [ADR_BIT-1:0]    adr1;
  logic [ADR_BIT-1:0]    adr2;

  assign kaydirma    = {adr_reg[OFS-1:0], 3'b000};
  assign maske_genis = {{BAYT{1'b0}}, boy_maske} << adr_reg[OFS-1:0];
  assign veri_genis  = {{VERI_BIT{1'b0}}, deger_reg & bayt_maske} << kaydirma;
  assign adr1        = {adr_reg[ADR_BIT-1:OFS], {OFS{1'b0}}};
  assign adr2        = adr1 + ADR_BIT'(BAYT);

  // Load assembly: bytes from both beats concatenated low-first, then extended.
  logic [2*VERI_BIT-1:0] okunan_genis;
  logic [VERI_BIT-1:0]   ham;
  logic                  isaret_bit;
  logic [VERI_BIT-1:0]   yuk_sonuc;

  // Select beat data, align to bit 0 and apply sign/zero extension.
  always_comb begin
    okunan_genis = {{VERI_BIT{1'b0}}, bib_veri_i};
    if (durum_reg == ISTEK2) begin
      okunan_genis = {bib_veri_i, veri1_reg};
    end
    ham = okunan_genis[kaydirma +: VERI_BIT];
    case (boyut_reg)
      2'd0:    isaret_bit = ham[7];
      2'd1:    isaret_bit = ham[15];
      2'd2:    isaret_bit = ham[31];
      default: isaret_bit = ham[VERI_BIT-1];
    endcase
    yuk_sonuc = (ham & bayt_maske) |
                ((isaret_bit && !isaretsiz_reg) ? ~bayt_maske : '0);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_reg <= BOSTA;
    end else begin
      durum_reg <= durum_next;
    end
  end

  // Next state, bus beat drive and datapath strobes.
  always_comb begin
    durum_next        = durum_reg;
    yakala            = 1'b0;
    hata_next         = 1'b0;
    veri1_al          = 1'b0;
    sonuc_al          = 1'b0;
    bitti_o           = 1'b0;
    bib_sec_o         = 1'b0;
    bib_adr_o         = '0;
    bib_veri_maske_o  = '0;
    bib_veri_o        = '0;
    bib_yaz_gecerli_o = 1'b0;
    case (durum_reg)
      BOSTA: begin
        if (basla_i) begin
          yakala    = 1'b1;
          hata_next = yasak_f(kontrol_i[1:0], kontrol_i[2], kontrol_i[3]) ||
                      (hizasiz_f(adr_i[OFS-1:0], kontrol_i[1:0]) && !HIZASIZ);
          durum_next = hata_next ? SONUC : ISTEK1;
        end
      end
      ISTEK1: begin
        bib_sec_o         = 1'b1;
        bib_adr_o         = adr1;
        bib_veri_maske_o  = maske_genis[BAYT-1:0];
        bib_veri_o        = yaz_reg ? veri_genis[VERI_BIT-1:0] : '0;
        bib_yaz_gecerli_o = yaz_reg;
        if (!bib_durdur_i) begin
`ifdef BIB_HIZASIZ_EN
          if (hizasiz_reg) begin
            veri1_al   = 1'b1;
            durum_next = ISTEK2;
          end else begin
            sonuc_al   = !yaz_reg;
            durum_next = SONUC;
          end
`else
          sonuc_al   = !yaz_reg;
          durum_next = SONUC;
`endif
        end
      end
`ifdef BIB_HIZASIZ_EN
      ISTEK2: begin
        bib_sec_o         = 1'b1;
        bib_adr_o         = adr2;
        bib_veri_maske_o  = maske_genis[2*BAYT-1:BAYT];
        bib_veri_o        = yaz_reg ? veri_genis[2*VERI_BIT-1:VERI_BIT] : '0;
        bib_yaz_gecerli_o = yaz_reg;
        if (!bib_durdur_i) begin
          sonuc_al   = !yaz_reg;
          durum_next = SONUC;
        end
      end
`endif
      SONUC: begin
        bitti_o = 1'b1;
        if (!ddb_durdur_i) begin
          durum_next = BOSTA;
        end
      end
      default: durum_next = BOSTA;
    endcase
  end

  // Operation capture, first-beat data and result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      yaz_reg       <= 1'b0;
      isaretsiz_reg <= 1'b0;
      boyut_reg     <= 2'd0;
      adr_reg       <= '0;
      deger_reg     <= '0;
      hizasiz_reg   <= 1'b0;
      veri1_reg     <= '0;
      sonuc_reg     <= '0;
      hata_reg      <= 1'b0;
    end else begin
      if (yakala) begin
        yaz_reg       <= kontrol_i[3];
        isaretsiz_reg <= kontrol_i[2];
        boyut_reg     <= kontrol_i[1:0];
        adr_reg       <= adr_i;
        deger_reg     <= deger_i;
        hizasiz_reg   <= hizasiz_f(adr_i[OFS-1:0], kontrol_i[1:0]);
        sonuc_reg     <= '0;
        hata_reg      <= hata_next;
      end
      if (veri1_al) begin
        veri1_reg <= bib_veri_i;
      end
      if (sonuc_al) begin
        sonuc_reg <= yuk_sonuc;
      end
    end
  end

  assign sonuc_o = sonuc_reg;
  assign hata_o  = hata_reg;

endmodule
